// File: rtl/bn_demux_1_n_stream_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer side, N consumer channels.
// The master modport is the producer/consumer environment; the slave modport is the demux.
interface bn_demux_1_n_stream_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int OUTPT_SIZE = 2 ** ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0]                  din;
    logic [ADDR_WIDTH-1:0]                  sel;
    logic                                   in_last;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [OUTPT_SIZE-1:0][DATA_WIDTH-1:0]  dout;
    logic [OUTPT_SIZE-1:0]                  out_valid;
    logic [OUTPT_SIZE-1:0]                  out_ready;
    logic [CNT_WIDTH-1:0]                   beat_cnt;
    logic                                   lock_active;

    modport master (
        output din, sel, in_last, in_valid, out_ready,
        input  in_ready, dout, out_valid, beat_cnt, lock_active
    );

    modport slave (
        input  din, sel, in_last, in_valid, out_ready,
        output in_ready, dout, out_valid, beat_cnt, lock_active
    );
endinterface

// File: rtl/bn_demux_1_n_stream.sv
// Registered 1-to-N stream demux with one output register per channel and a beat counter.
// Define BN_DEMUX_PACKET_LOCK_EN to hold the destination channel for a whole packet.
module bn_demux_1_n_stream #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int OUTPT_SIZE = 2 ** ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bn_demux_1_n_stream_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] L_SIZE = OUTPT_SIZE[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0]                  w_dst;
    logic                                   w_in_range;
    logic                                   w_in_ready;
    logic                                   w_accept;
    logic [OUTPT_SIZE-1:0]                  w_load;
    logic [OUTPT_SIZE-1:0]                  w_drain;

    logic [OUTPT_SIZE-1:0][DATA_WIDTH-1:0]  r_dout;
    logic [OUTPT_SIZE-1:0]                  r_out_valid;
    logic [CNT_WIDTH-1:0]                   r_beat_cnt;

`ifdef BN_DEMUX_PACKET_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_lock_ch;

    assign w_dst = (r_state == ST_LOCKED) ? r_lock_ch : bus.sel;

    // A multi-beat packet pins its first beat's channel until the last beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE && !bus.in_last) begin
                r_state   <= ST_LOCKED;
                r_lock_ch <= bus.sel;
            end else if (r_state == ST_LOCKED && bus.in_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.lock_active = (r_state == ST_LOCKED);
`else
    logic w_unused_last;

    assign w_unused_last   = bus.in_last;
    assign w_dst           = bus.sel;
    assign bus.lock_active = 1'b0;
`endif

    // Readiness looks only at the addressed channel, so a stalled neighbour never blocks.
    assign w_in_range = ({1'b0, w_dst} < L_SIZE);
    assign w_in_ready = w_in_range && (!r_out_valid[w_dst] || bus.out_ready[w_dst]);
    assign w_accept   = bus.in_valid && w_in_ready;

    for (genvar gi = 0; gi < OUTPT_SIZE; gi++) begin : g_chan
        assign w_load[gi]  = w_accept && (w_dst == ADDR_WIDTH'(gi));
        assign w_drain[gi] = r_out_valid[gi] && bus.out_ready[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_out_valid <= '0;
            r_beat_cnt  <= '0;
        end else begin
            for (int k = 0; k < OUTPT_SIZE; k++) begin
                if (w_load[k]) begin
                    r_dout[k]      <= bus.din;
                    r_out_valid[k] <= 1'b1;
                end else if (w_drain[k]) begin
                    r_out_valid[k] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.dout      = r_dout;
    assign bus.out_valid = r_out_valid;
    assign bus.beat_cnt  = r_beat_cnt;
endmodule

// File: tb/tb_bn_demux_1_n_stream.sv
// Randomised and directed bench for bn_demux_1_n_stream against a channel-level reference model.
// Lock checks are active when BN_DEMUX_PACKET_LOCK_EN is defined.
module tb_bn_demux_1_n_stream;
    localparam int DW = 4;
    localparam int AW = 2;
    localparam int NCH = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bn_demux_1_n_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPT_SIZE(NCH), .CNT_WIDTH(CW)) bus ();

    bn_demux_1_n_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPT_SIZE(NCH), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_mode = 0;

    // Reference model: what each channel register holds, plus the counter and lock.
    logic [NCH-1:0] m_valid;
    logic [DW-1:0]  m_dout [NCH];
    logic [CW-1:0]  m_cnt;
    bit             m_lock;
    int             m_lock_ch;
    bit             m_acc;
    int             m_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_dst();
        return m_lock ? m_lock_ch : int'(bus.sel);
    endfunction

    function automatic bit model_ready();
        int d = m_dst();
        return (d < NCH) && (!m_valid[d] || bus.out_ready[d]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = '0;
            for (int k = 0; k < NCH; k++) m_dout[k] = '0;
            m_cnt  = '0;
            m_lock = 0;
            m_lock_ch = 0;
        end else begin
            m_acc = bus.in_valid && model_ready();
            m_d   = m_dst();
            for (int k = 0; k < NCH; k++) begin
                if (m_acc && m_d == k) begin
                    m_valid[k] = 1'b1;
                    m_dout[k]  = bus.din;
                end else if (m_valid[k] && bus.out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (m_acc) m_cnt = m_cnt + 1'b1;
`ifdef BN_DEMUX_PACKET_LOCK_EN
            if (m_acc) begin
                if (!m_lock && !bus.in_last) begin
                    m_lock = 1;
                    m_lock_ch = int'(bus.sel);
                end else if (m_lock && bus.in_last) begin
                    m_lock = 0;
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            for (int k = 0; k < NCH; k++) check($sformatf("dout[%0d]", k), 32'(bus.dout[k]), 32'(m_dout[k]));
            check("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
            check("lock_active", 32'(bus.lock_active), 32'(m_lock));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) bus.out_ready = NCH'($urandom);
    end

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] s, input logic l);
        bit ok = 0;
        int waited = 0;
        bus.din = d;
        bus.sel = s;
        bus.in_last = l;
        bus.in_valid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = model_ready();
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        $display("beat din=%0h sel=%0d last=%0b cnt=%0d", d, s, l, bus.beat_cnt);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.din = '0;
        bus.sel = '0;
        bus.in_last = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = '0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_beat_cnt", 32'(bus.beat_cnt), 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routing
        bus.out_ready = 4'hF;
        send(4'hA, 2'd1, 1'b1);
        check("route_v1", 32'(bus.out_valid[1]), 32'h1);
        check("route_d1", 32'(bus.dout[1]), 32'hA);
        send(4'h5, 2'd3, 1'b1);
        check("route_v3", 32'(bus.out_valid[3]), 32'h1);
        check("route_d3", 32'(bus.dout[3]), 32'h5);
        check("route_v1_drained", 32'(bus.out_valid[1]), 32'h0);
        check("route_cnt", 32'(bus.beat_cnt), 32'h2);

        // Backpressure on channel 2
        bus.out_ready = 4'b1011;
        send(4'h7, 2'd2, 1'b1);
        check("bp_d2_loaded", 32'(bus.dout[2]), 32'h7);
        bus.din = 4'h9;
        bus.sel = 2'd2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("bp_d2_held", 32'(bus.dout[2]), 32'h7);
        check("bp_v2_held", 32'(bus.out_valid[2]), 32'h1);
        send(4'h9, 2'd0, 1'b1);
        check("bp_sel0_cnt", 32'(bus.beat_cnt), 32'h4);
        bus.out_ready = 4'hF;
        send(4'h9, 2'd2, 1'b1);
        check("bp_d2_new", 32'(bus.dout[2]), 32'h9);
        check("bp_cnt", 32'(bus.beat_cnt), 32'h5);
        idle(1);

        // Same-cycle drain and load
        bus.out_ready = 4'b1101;
        send(4'h1, 2'd1, 1'b1);
        bus.out_ready = 4'hF;
        send(4'h3, 2'd1, 1'b1);
        check("dl_v1", 32'(bus.out_valid[1]), 32'h1);
        check("dl_d1", 32'(bus.dout[1]), 32'h3);
        idle(2);

`ifdef BN_DEMUX_PACKET_LOCK_EN
        send(4'h1, 2'd2, 1'b0);
        check("lock_on", 32'(bus.lock_active), 32'h1);
        check("lock_b1", 32'(bus.dout[2]), 32'h1);
        send(4'h2, 2'd0, 1'b0);
        check("lock_b2", 32'(bus.dout[2]), 32'h2);
        send(4'h3, 2'd3, 1'b1);
        check("lock_b3", 32'(bus.dout[2]), 32'h3);
        check("lock_off", 32'(bus.lock_active), 32'h0);
        send(4'h4, 2'd0, 1'b1);
        check("lock_free_d0", 32'(bus.dout[0]), 32'h4);
        check("lock_free_v0", 32'(bus.out_valid[0]), 32'h1);
        idle(2);
`else
        send(4'h6, 2'd2, 1'b0);
        check("nolock_active", 32'(bus.lock_active), 32'h0);
        send(4'h8, 2'd0, 1'b0);
        check("nolock_d0", 32'(bus.dout[0]), 32'h8);
        idle(2);
`endif

        // Asynchronous reset mid-cycle with channel 2 holding data
        bus.out_ready = 4'b1011;
        send(4'h7, 2'd2, 1'b1);
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'h0);
        check("arst_dout", 32'(bus.dout), 32'h0);
        check("arst_beat_cnt", 32'(bus.beat_cnt), 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold", 32'(bus.out_valid), 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counter wrap after 256 accepts
        bus.out_ready = 4'hF;
        for (int i = 0; i < 256; i++) send(DW'(i), AW'(i % NCH), 1'b1);
        check("wrap_cnt", 32'(bus.beat_cnt), 32'h0);
        idle(1);

        // Random traffic with random consumer stalls
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(DW'($urandom), AW'($urandom_range(0, NCH - 1)), 1'($urandom_range(0, 2) == 0));
        end
        rand_mode = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 4'hF;
        idle(4);
        check("final_drained", 32'(bus.out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bn_demux_1_n_stream.md
Name: bN_demux_1_N_stream

Overview:
- Registered, handshaked 1-to-N stream demultiplexer, parametrised in data width and channel count.
- Each accepted input beat is routed by `sel` into a one-entry output register of the addressed channel.
- Each channel drains independently through its own valid/ready handshake.
- Sits between a single producer and N consumer pipelines. Adds buffering, backpressure and a beat counter that a purely combinational demux does not have.

Parameters:
- DATA_WIDTH, 4, width of one data beat.
- ADDR_WIDTH, 2, width of `sel`.
- OUTPT_SIZE, 2**ADDR_WIDTH, number of output channels; must be ≤ 2**ADDR_WIDTH.
- CNT_WIDTH, 8, width of the accepted-beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  input beat data.
- sel  input  ADDR_WIDTH  destination channel of the current beat.
- in_last  input  1  last beat of a packet; used only with PACKET_LOCK_EN.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- dout  output  [OUTPT_SIZE-1:0][DATA_WIDTH-1:0]  packed per-channel data registers.
- out_valid  output  OUTPT_SIZE  per-channel valid.
- out_ready  input  OUTPT_SIZE  per-channel consumer ready.
- beat_cnt  output  CNT_WIDTH  accepted-beat counter.
- lock_active  output  1  packet lock held; constant 0 without PACKET_LOCK_EN.

Behaviour:
- **Reset** (rst_n low, asynchronous): out_valid = 0, dout = all zeros, beat_cnt = 0, lock state cleared. State remains held while rst_n is low. Reset mid-transfer discards all buffered beats.
- **Effective destination:** dst = sel, or the locked channel when the lock is active (see Optional Feature).
- **in_ready** (combinational) = (dst < OUTPT_SIZE) && (!out_valid[dst] || out_ready[dst]).
  - Depends only on the dst channel; other channels' stalls never block it.
- **Accept** = in_valid && in_ready. On the next edge:
  - dout[dst] <= din, out_valid[dst] <= 1, beat_cnt <= beat_cnt + 1.
  - beat_cnt wraps modulo 2**CNT_WIDTH with no saturation.
- **Drain:** channel k with out_valid[k] && out_ready[k] and no simultaneous load clears out_valid[k] next edge.
  - Simultaneous drain and load on the same channel: out_valid stays 1, dout takes the new beat. This gives full throughput of 1 beat/cycle per channel.
- **Stall:** out_valid[k] && !out_ready[k] → dout[k] and out_valid[k] hold.
  - An incoming beat to k is stalled with in_ready = 0.
  - Data and sel must be held stable by the producer (AXI-style rule: valid is never withdrawn before the handshake).
- **Idle data:** dout[k] retains its last loaded value after draining; it is not zeroed.
- **Parallelism:** different channels drain in the same cycle independently.
- **Latency:** 1 cycle from accept to out_valid.
- **Out of range:** sel ≥ OUTPT_SIZE (when OUTPT_SIZE < 2**ADDR_WIDTH) → in_ready = 0, beat never accepted, no state change.
- in_valid = 0 → no state change except drains.

Optional Feature:
- Macro: BN_DEMUX_PACKET_LOCK_EN.
- **Defined:** packet-lock FSM with states IDLE and LOCKED.
  - IDLE: accept with in_last = 0 → LOCKED, capturing lock_ch = sel. An accept with in_last = 1 stays IDLE (single-beat packet).
  - LOCKED: dst = lock_ch and sel is ignored. Accept with in_last = 1 → IDLE.
  - lock_active = 1 in LOCKED.
  - Reset → IDLE.
- **Not defined:** in_last is ignored, dst = sel on every beat, lock_active tied to 0, no FSM logic synthesised.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=2, OUTPT_SIZE=4, CNT_WIDTH=8):
- **Reset:** assert rst_n = 0 mid-cycle with channel 2 valid → out_valid = 0000, dout = 0, beat_cnt = 0 immediately, without waiting for a clock edge.
- **Routing:** all out_ready = 1; send din = 0xA sel = 1, then din = 0x5 sel = 3 on consecutive cycles → out_valid[1] one cycle after the first accept with dout[1] = 0xA, then out_valid[3] with dout[3] = 0x5; beat_cnt = 2.
- **Backpressure:** out_ready[2] = 0 with channel 2 valid holding 0x7; send din = 0x9 sel = 2 → in_ready = 0 and dout[2] stays 0x7. Send sel = 0 the next cycle → accepted. Raise out_ready[2] → 0x9 loads the cycle after accept.
- **Same-cycle drain+load:** channel 1 valid, out_ready[1] = 1, accept 0x3 to sel = 1 → out_valid[1] stays 1 and dout[1] = 0x3.
- **Counter wrap:** 256 accepts → beat_cnt returns to 0x00.
- **Lock (macro defined):** beats sel = 2, 0, 3 with in_last = 0, 0, 1 → all three land on channel 2, lock_active is 1 after the first beat and 0 after the third, and the next beat with sel = 0 lands on channel 0.
